l2_bank_rr_arbiter: RTL and testbench
=====================================

# l2_bank_rr_arbiter

Per-bank round-robin arbiter that sits directly upstream of one interleaved L2 SRAM bank port. It merges NB_MASTERS TCDM-style requesters onto the single bank slave port, forwards the winner's payload combinationally, and records the winner so that the bank's one-cycle read response is routed back to the right master. It also flags protocol violations on the bank response path.

## Interface
Parameters:
- NB_MASTERS, default 4: number of requesting masters; must be ≥2.
- ADDR_WIDTH, default 32: byte address width.
- DATA_WIDTH, default 32: data width; BE width is DATA_WIDTH/8.

Ports:
- clk_i, in, 1: clock. One clock domain.
- rst_ni, in, 1: reset, asynchronous, active-low.
- m_req_i, in, NB_MASTERS: per-master request.
- m_add_i, in, NB_MASTERS×ADDR_WIDTH: per-master byte address.
- m_wen_i, in, NB_MASTERS: per-master write-enable, active-low (1 = read).
- m_wdata_i, in, NB_MASTERS×DATA_WIDTH: per-master write data.
- m_be_i, in, NB_MASTERS×DATA_WIDTH/8: per-master byte enables.
- m_gnt_o, out, NB_MASTERS: one-hot grant.
- m_r_valid_o, out, NB_MASTERS: one-hot response valid.
- m_r_rdata_o, out, DATA_WIDTH: response data, broadcast to all masters.
- s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o, out: bank-side request and payload.
- s_gnt_i, in, 1: bank grant.
- s_r_valid_i, in, 1: bank response valid.
- s_r_rdata_i, in, DATA_WIDTH: bank read data.
- err_o, out, 1: sticky flag for an unexpected response.

## Operation
- State: rr_q (priority pointer, log2 NB_MASTERS bits), resp_idx_q (master index), pending_q (1 bit), err_q (1 bit).
- Winner: the first master with m_req_i set, searching cyclically from rr_q upward and wrapping from NB_MASTERS-1 to 0.
- s_req_o = OR of m_req_i.
- s_add/wen/wdata/be_o = winner's fields. When no master requests, they carry master rr_q's fields; their value is don't-care.
- m_gnt_o[winner] = s_gnt_i & s_req_o. All other grant bits are 0.
- On a handshake (s_req_o & s_gnt_i):
  - rr_q <= (winner+1) mod NB_MASTERS.
  - resp_idx_q <= winner.
  - pending_q <= 1.
- With no handshake, pending_q <= 0 and rr_q holds.
- Back-to-back handshakes each cycle are legal. pending_q stays 1 and resp_idx_q updates every cycle.
- m_r_valid_o[k] = s_r_valid_i & pending_q & (resp_idx_q==k).
- m_r_rdata_o = s_r_rdata_i, unregistered.
- Reads and writes both produce a response.
- err_q <= err_q | (s_r_valid_i & ~pending_q). The unexpected response is dropped: no m_r_valid_o bit rises. err_o = err_q, cleared only by reset.
- Request changes while the bank withholds s_gnt_i:
  - The winner is recomputed every cycle.
  - A master that drops m_req_i before being granted simply loses its slot. No state changes.
  - rr_q never advances without a handshake.

## Timing
- Reset values: rr_q=0, resp_idx_q=0, pending_q=0, err_q=0.
- While rst_ni=0, m_r_valid_o=0 and err_o=0. m_gnt_o and s_* follow the inputs combinationally.
- Request path: zero latency, input to s_* combinational.
- Response path: m_r_valid_o asserts in the cycle after the handshake, when the bank returns s_r_valid_i one cycle after gnt.
- The bank must have fixed one-cycle latency. Responses arriving at any other time are treated as unexpected.
- Reset asserted mid-transaction clears pending_q immediately. A response arriving in the cycle after reset is released is therefore reported in err_o and dropped.
- NB_MASTERS not a power of two: rr_q wraps explicitly at NB_MASTERS-1 and never takes unused encodings.

## Test plan
- Single master: NB_MASTERS=4, master 2 reads add 0x1C01_0008 with s_gnt_i tied to s_req_o.
  - Required: m_gnt_o=4'b0100 and s_add_o=0x1C01_0008 in the same cycle.
  - Next cycle: m_r_valid_o=4'b0100, m_r_rdata_o equals the bank data, rr_q=3.
- Full contention: all 4 masters hold req for 8 cycles. Required grant sequence: 0,1,2,3,0,1,2,3, with each response routed to the master granted in the prior cycle.
- Wrap-around: rr_q=3, only masters 0 and 3 request. Required: master 3 granted, then master 0, then master 3.
- Bank stall: s_gnt_i=0 for 3 cycles while masters 1 and 2 request.
  - Required: m_gnt_o=0 throughout, rr_q unchanged, no m_r_valid_o.
  - When s_gnt_i rises: master 1 granted first.
- Unexpected response: pulse s_r_valid_i with pending_q=0. Required: m_r_valid_o=0, err_o=1 from the next cycle, held until rst_ni low.
- Reset mid-operation: assert rst_ni low in the cycle after a handshake. Required: m_r_valid_o=0 immediately and rr_q=0; the next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter for one interleaved L2 SRAM bank port.
// Ports: m_* master side (req/payload in, gnt/r_valid/rdata out),
//        s_* bank side (req/payload out, gnt/r_valid/rdata in),
//        err_o sticky flag for responses the bank sent unasked.
module l2_bank_rr_arbiter #(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_W = DATA_WIDTH / 8,
  localparam int unsigned IW =
    (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NB_MASTERS-1:0]                  m_req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  m_add_i,
  input  logic [NB_MASTERS-1:0]                  m_wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NB_MASTERS-1:0][BE_W-1:0]        m_be_i,
  output logic [NB_MASTERS-1:0]                  m_gnt_o,
  output logic [NB_MASTERS-1:0]                  m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                  m_r_rdata_o,
  output logic                                   s_req_o,
  output logic [ADDR_WIDTH-1:0]                  s_add_o,
  output logic                                   s_wen_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  output logic [BE_W-1:0]                        s_be_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  s_r_rdata_i,
  output logic                                   err_o
);

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] resp_idx_q, resp_idx_d;
  logic          pending_q, pending_d;
  logic          err_q, err_d;

  logic [IW-1:0] win;
  logic [IW:0]   cand_w;
  logic [IW-1:0] cand;
  logic          found;
  logic          hs;

  // Cyclic search from rr_q; the extra bit lets the sum
  // wrap explicitly for non power-of-two master counts.
  always_comb begin
    win    = rr_q;
    found  = 1'b0;
    cand_w = '0;
    cand   = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      cand_w = {1'b0, rr_q} + (IW+1)'(i);
      if (cand_w >= (IW+1)'(NB_MASTERS))
        cand_w = cand_w - (IW+1)'(NB_MASTERS);
      cand = cand_w[IW-1:0];
      if (!found && m_req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign s_req_o   = |m_req_i;
  assign s_add_o   = m_add_i[win];
  assign s_wen_o   = m_wen_i[win];
  assign s_wdata_o = m_wdata_i[win];
  assign s_be_o    = m_be_i[win];

  assign hs = s_req_o & s_gnt_i;

  always_comb begin
    m_gnt_o      = '0;
    m_gnt_o[win] = hs;
  end

  always_comb begin
    for (int k = 0; k < NB_MASTERS; k++)
      m_r_valid_o[k] = s_r_valid_i & pending_q &
                       (resp_idx_q == IW'(k));
  end

  assign m_r_rdata_o = s_r_rdata_i;
  assign err_o       = err_q;

  always_comb begin
    rr_d       = rr_q;
    resp_idx_d = resp_idx_q;
    pending_d  = hs;
    err_d      = err_q | (s_r_valid_i & ~pending_q);
    if (hs) begin
      resp_idx_d = win;
      if (win == IW'(NB_MASTERS - 1))
        rr_d = '0;
      else
        rr_d = win + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      resp_idx_q <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      resp_idx_q <= resp_idx_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Bench for l2_bank_rr_arbiter: directed scenarios plus
// random traffic checked against a cycle model every cycle.
module tb_l2_bank_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_ni;
  logic [N-1:0]         m_req;
  logic [N-1:0][AW-1:0] m_add;
  logic [N-1:0]         m_wen;
  logic [N-1:0][DW-1:0] m_wdata;
  logic [N-1:0][BW-1:0] m_be;
  logic [N-1:0]         m_gnt;
  logic [N-1:0]         m_rv;
  logic [DW-1:0]        m_rdata;
  logic                 s_req;
  logic [AW-1:0]        s_add;
  logic                 s_wen;
  logic [DW-1:0]        s_wdata;
  logic [BW-1:0]        s_be;
  logic                 s_gnt;
  logic                 s_rv;
  logic [DW-1:0]        s_rdata;
  logic                 err;

  l2_bank_rr_arbiter #(
    .NB_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req), .m_add_i(m_add), .m_wen_i(m_wen),
    .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(m_gnt), .m_r_valid_o(m_rv),
    .m_r_rdata_o(m_rdata),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen),
    .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_r_valid_i(s_rv),
    .s_r_rdata_i(s_rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference state: priority start, response owner, flags
  int rr, ridx;
  bit pend, merr;
  int last_w;
  bit last_hs;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (m_req[(rr + k) % N]) return (rr + k) % N;
    return rr;
  endfunction

  task automatic model_reset();
    rr = 0; ridx = 0; pend = 0; merr = 0;
  endtask

  // called at posedge+1; compares at the falling edge
  task automatic check();
    logic [N-1:0] one;
    logic [N-1:0] eg, erv;
    int w;
    bit any, hs;
    one = 1;
    #4;
    any = |m_req;
    w   = winner();
    hs  = any && s_gnt;
    eg  = hs ? (one << w) : '0;
    erv = (s_rv && pend) ? (one << ridx) : '0;
    chk("gnt", m_gnt, eg);
    chk("s_req", s_req, any);
    if (any) begin
      chk("s_add", s_add, m_add[w]);
      chk("s_wen", s_wen, m_wen[w]);
      chk("s_wdata", s_wdata, m_wdata[w]);
      chk("s_be", s_be, m_be[w]);
    end
    chk("r_valid", m_rv, erv);
    chk("rdata", m_rdata, s_rdata);
    chk("err", err, merr);
    last_w  = w;
    last_hs = hs;
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_ni) begin
      model_reset();
    end else begin
      merr = merr | (s_rv && !pend);
      if (last_hs) begin
        rr   = (last_w + 1) % N;
        ridx = last_w;
        pend = 1;
      end else begin
        pend = 0;
      end
    end
    #1;
  endtask

  task automatic rand_payload();
    for (int m = 0; m < N; m++) begin
      m_add[m]   = $urandom;
      m_wdata[m] = $urandom;
      m_be[m]    = BW'($urandom);
      m_wen[m]   = 1'($urandom);
    end
  endtask

  // well-behaved bank: answers exactly one cycle after gnt
  task automatic bank_ok();
    s_rv    = pend;
    s_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    m_req = '0; s_gnt = 1'b0; s_rv = 1'b0;
    check();
    chk("rst_rv", m_rv, 0);
    chk("rst_err", err, 0);
    adv();
    adv();
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [N-1:0] one;
    int exp_seq [3];
    one = 1;
    rst_ni = 1'b0;
    m_req = '0; s_gnt = 1'b0; s_rv = 1'b0; s_rdata = '0;
    rand_payload();
    model_reset();
    #1;
    do_reset();

    // single master read from master 2
    rand_payload();
    m_add[2] = 32'h1C01_0008;
    m_req = 4'b0100; s_gnt = 1'b1; bank_ok();
    check();
    chk("single_gnt", m_gnt, 4'b0100);
    chk("single_add", s_add, 32'h1C01_0008);
    adv();
    m_req = '0; s_gnt = 1'b0;
    s_rv = 1'b1; s_rdata = 32'hDEAD_BEEF;
    check();
    chk("single_rv", m_rv, 4'b0100);
    chk("single_rdata", m_rdata, 32'hDEAD_BEEF);
    adv();

    // wrap-around: pointer now at 3, masters 0 and 3
    exp_seq = '{3, 0, 3};
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      m_req = 4'b1001; s_gnt = 1'b1; bank_ok();
      check();
      chk("wrap_gnt", m_gnt, one << exp_seq[i]);
      adv();
    end

    // full contention for 8 cycles
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      m_req = 4'b1111; s_gnt = 1'b1; bank_ok();
      check();
      chk("cont_gnt", m_gnt, one << (i % 4));
      if (i > 0)
        chk("cont_rv", m_rv, one << ((i - 1) % 4));
      adv();
    end

    // bank stall, masters 1 and 2
    for (int i = 0; i < 4; i++) begin
      rand_payload();
      m_req = 4'b0110; s_gnt = (i == 3); bank_ok();
      check();
      if (i == 3)
        chk("stall_first", m_gnt, 4'b0010);
      else begin
        chk("stall_gnt", m_gnt, 0);
        if (i > 0) chk("stall_rv", m_rv, 0);
      end
      adv();
    end

    // expected response, then an unexpected one
    m_req = '0; s_gnt = 1'b0; bank_ok();
    check();
    chk("exp_rv", m_rv, 4'b0010);
    adv();
    s_rv = 1'b1; s_rdata = $urandom;
    check();
    chk("unexp_rv", m_rv, 0);
    chk("unexp_err0", err, 0);
    adv();
    s_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check();
      chk("unexp_err1", err, 1);
      adv();
    end

    // reset in the cycle after a handshake
    rand_payload();
    m_req = 4'b1000; s_gnt = 1'b1; bank_ok();
    check();
    adv();
    rst_ni = 1'b0;
    model_reset();
    m_req = '0; s_rv = 1'b1;
    check();
    chk("rstmid_rv", m_rv, 0);
    chk("rstmid_err", err, 0);
    adv();
    rst_ni = 1'b1;
    rand_payload();
    m_req = 4'b1010; s_gnt = 1'b1; s_rv = 1'b1;
    check();
    chk("rstmid_gnt", m_gnt, 4'b0010);
    chk("rstmid_rv2", m_rv, 0);
    adv();
    m_req = '0; s_gnt = 1'b0; s_rv = 1'b0;
    check();
    chk("rstmid_err1", err, 1);
    adv();

    do_reset();

    // random traffic with an occasionally misbehaving bank
    for (int c = 0; c < 3000; c++) begin
      rand_payload();
      m_req   = N'($urandom);
      s_gnt   = ($urandom_range(0, 3) != 0);
      s_rv    = pend ^ ($urandom_range(0, 199) == 0);
      s_rdata = $urandom;
      check();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
